// File: rtl/imm_alloc.sv
// imm_alloc -- group allocator for a 4-wide immediate file.
//
// A decode bundle carrying up to four immediates asks for one group of
// four entries. The allocator keeps one busy bit per group, grants the
// first free group combinationally, and forwards the immediates to the
// immediate file with a one-hot group write select. Commit releases
// groups through a multi-hot mask; flush frees everything.
//
// Optional feature: define IMM_ALLOC_RR_EN to search for a free group
// starting at a rotating pointer (one past the last granted group)
// instead of fixed priority from group 0.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req                   bundle requests one group
//   i_imm0..i_imm3          immediates of the requesting bundle
//   i_rel_mask[GROUPS]      groups released by commit this cycle
//   i_flush                 pipeline kill, frees every group
//   o_grant, o_we           request accepted / immediate file write enable
//   o_waddr[GROUPS]         one-hot group select (zero without grant)
//   o_wdata0..o_wdata3      immediates passed through
//   o_base[AW]              entry index of the granted group (group*4)
//   o_full, o_count[CW]     all groups busy / number of busy groups
module imm_alloc #(
    parameter  int SIZE   = 32,
    parameter  int WIDTH  = 32,
    localparam int GROUPS = SIZE / 4,
    localparam int AW     = $clog2(SIZE),
    localparam int CW     = $clog2(GROUPS) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [WIDTH-1:0]  i_imm0,
    input  logic [WIDTH-1:0]  i_imm1,
    input  logic [WIDTH-1:0]  i_imm2,
    input  logic [WIDTH-1:0]  i_imm3,
    input  logic [GROUPS-1:0] i_rel_mask,
    input  logic              i_flush,
    output logic              o_grant,
    output logic              o_we,
    output logic [GROUPS-1:0] o_waddr,
    output logic [WIDTH-1:0]  o_wdata0,
    output logic [WIDTH-1:0]  o_wdata1,
    output logic [WIDTH-1:0]  o_wdata2,
    output logic [WIDTH-1:0]  o_wdata3,
    output logic [AW-1:0]     o_base,
    output logic              o_full,
    output logic [CW-1:0]     o_count
);

    localparam int GW = $clog2(GROUPS);

    logic [GROUPS-1:0] busy;
    logic [GROUPS-1:0] busy_nxt;
    logic [CW-1:0]     count_nxt;
    logic [GW-1:0]     sel;
    logic              found;
    logic [GW-1:0]     start;
    logic              grant;

`ifdef IMM_ALLOC_RR_EN
    logic [GW-1:0] ptr;

    assign start = ptr;

    // Pointer moves one past the granted group; flush never grants, so it
    // leaves the pointer where it was.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ptr <= '0;
        else if (grant)
            ptr <= (int'(sel) == GROUPS - 1) ? '0 : sel + GW'(1);
    end
`else
    assign start = '0;
`endif

    // First free group at or after start, wrapping modulo GROUPS.
    // Only the registered busy vector is searched, so a group released
    // this cycle cannot be handed out until the next one.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < GROUPS; i++) begin
            idx = (int'(start) + i) % GROUPS;
            if (!found && !busy[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
    end

    assign o_full  = &busy;
    // i_rst_n gating keeps the write port quiet while reset is held.
    assign grant   = i_rst_n & i_req & ~o_full & ~i_flush & found;
    assign o_grant = grant;
    assign o_we    = grant;
    assign o_waddr = grant ? (GROUPS'(1) << sel) : '0;
    assign o_base  = grant ? AW'({sel, 2'b00}) : '0;

    assign o_wdata0 = i_imm0;
    assign o_wdata1 = i_imm1;
    assign o_wdata2 = i_imm2;
    assign o_wdata3 = i_imm3;

    // Release is applied to the old busy vector before the new grant is
    // or-ed in: a release aimed at the (free) group being granted is a
    // no-op and must not cancel the grant.
    always_comb begin
        busy_nxt  = '0;
        count_nxt = '0;
        if (!i_flush)
            busy_nxt = (busy & ~i_rel_mask) | o_waddr;
        for (int i = 0; i < GROUPS; i++)
            count_nxt = count_nxt + CW'(busy_nxt[i]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy    <= '0;
            o_count <= '0;
        end else begin
            busy    <= busy_nxt;
            o_count <= count_nxt;
        end
    end

endmodule
